// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register file with integrated write scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int PEND_W_DEF = 2;
    localparam int AW_DEF     = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]     reg_addr_t;
    typedef logic [PEND_W_DEF-1:0] pend_cnt_t;

endpackage

// File: rtl/regfile_pend_ctr.sv
// Saturating pending-write counter for one architectural register.
// The multi output exists only when REGFILE_BYPASS_EN is defined.
module regfile_pend_ctr
    import regfile_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic nonzero,
`ifdef REGFILE_BYPASS_EN
    output logic multi,
`endif
    output logic underflow
);

    logic [PEND_W-1:0] cnt;
    logic              inc_ok;
    logic              dec_ok;

    assign full      = &cnt;
    assign nonzero   = |cnt;
    assign inc_ok    = inc && !full;
    assign dec_ok    = dec && nonzero;
    assign underflow = dec && !nonzero;
`ifdef REGFILE_BYPASS_EN
    assign multi     = (cnt > PEND_W'(1));
`endif

    // A simultaneous issue and write-back to the same register cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc_ok && !dec_ok) begin
            cnt <= cnt + PEND_W'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt <= cnt - PEND_W'(1);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two async read ports, one write-back port and per-register pending counters.
// Define REGFILE_BYPASS_EN to forward a same-cycle write-back onto the read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  XLEN   = XLEN_DEF,
    parameter int  NREGS  = NREGS_DEF,
    parameter int  PEND_W = PEND_W_DEF,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            sb_err
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] inc;
    logic [NREGS-1:0] dec;
    logic [NREGS-1:0] full;
    logic [NREGS-1:0] nonzero;
    logic [NREGS-1:0] underflow;
`ifdef REGFILE_BYPASS_EN
    logic [NREGS-1:0] multi;
    assign multi[0] = 1'b0;
`endif

    // Register 0 is never pending and never full, so its slot is tied off.
    assign inc[0]       = 1'b0;
    assign dec[0]       = 1'b0;
    assign full[0]      = 1'b0;
    assign nonzero[0]   = 1'b0;
    assign underflow[0] = 1'b0;

    assign iss_ready = !full[iss_rd];

    for (genvar r = 1; r < NREGS; r++) begin : g_ctr
        assign inc[r] = iss_valid && iss_ready && (iss_rd == AW'(r));
        assign dec[r] = wb_valid && (wb_addr == AW'(r));

        regfile_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .full      (full[r]),
            .nonzero   (nonzero[r]),
`ifdef REGFILE_BYPASS_EN
            .multi     (multi[r]),
`endif
            .underflow (underflow[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // A write-back with nothing pending still lands, but is flagged until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_err <= 1'b0;
        end else if (|underflow) begin
            sb_err <= 1'b1;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
        rs1_busy = nonzero[rs1_addr];
        rs2_busy = nonzero[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && (wb_addr == rs1_addr) && (rs1_addr != '0)) begin
            rs1_data = wb_data;
            rs1_busy = multi[rs1_addr];
        end
        if (wb_valid && (wb_addr == rs2_addr) && (rs2_addr != '0)) begin
            rs2_data = wb_data;
            rs2_busy = multi[rs2_addr];
        end
`endif
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a behavioural model queues expected outputs per step.
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;

    localparam int NREGS = 32;
    localparam int PMAX  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        sb_err;

    regfile_scoreboard dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic        rdy;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_regs [NREGS];
    int          m_cnt  [NREGS];
    logic        m_err;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [31:0] expData(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && int'(wb_addr) == a) return wb_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic expBusy(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && int'(wb_addr) == a) return m_cnt[a] > 1;
`endif
        return m_cnt[a] != 0;
    endfunction

    task automatic pushExpected(input string tag);
        exp_t e;
        e.tag = tag;
        e.d1  = expData(int'(rs1_addr));
        e.d2  = expData(int'(rs2_addr));
        e.b1  = expBusy(int'(rs1_addr));
        e.b2  = expBusy(int'(rs2_addr));
        e.rdy = (iss_rd == '0) || (m_cnt[int'(iss_rd)] != PMAX);
        e.err = m_err;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty observed=0 entries expected=1");
            return;
        end
        e = sb_q.pop_front();
        cmp({e.tag, ".rs1_data"}, rs1_data, e.d1);
        cmp({e.tag, ".rs2_data"}, rs2_data, e.d2);
        cmp({e.tag, ".rs1_busy"}, 32'(rs1_busy), 32'(e.b1));
        cmp({e.tag, ".rs2_busy"}, 32'(rs2_busy), 32'(e.b2));
        cmp({e.tag, ".iss_ready"}, 32'(iss_ready), 32'(e.rdy));
        cmp({e.tag, ".sb_err"}, 32'(sb_err), 32'(e.err));
    endtask

    // Advances the model past the coming clock edge using the inputs now applied.
    task automatic modelStep();
        int   wa;
        int   ird;
        logic acc;
        logic dec;
        wa  = int'(wb_addr);
        ird = int'(iss_rd);
        acc = iss_valid && (ird == 0 || m_cnt[ird] != PMAX);
        dec = 1'b0;
        if (wb_valid && wa != 0) begin
            m_regs[wa] = wb_data;
            if (m_cnt[wa] == 0) m_err = 1'b1;
            else dec = 1'b1;
        end
        if (dec) m_cnt[wa]--;
        if (acc && ird != 0) m_cnt[ird]++;
    endtask

    task automatic applyStimulus(input string tag, input logic iv, input int ird,
                                 input logic wv, input int wa, input logic [31:0] wd,
                                 input int a1, input int a2);
        @(negedge clk);
        iss_valid = iv;
        iss_rd    = 5'(ird);
        wb_valid  = wv;
        wb_addr   = 5'(wa);
        wb_data   = wd;
        rs1_addr  = 5'(a1);
        rs2_addr  = 5'(a2);
        #1;
        pushExpected(tag);
        checkOutput();
        modelStep();
    endtask

    task automatic midReset(input int a1, input int a2);
        @(negedge clk);
        iss_valid = 1'b0;
        iss_rd    = '0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        rs1_addr  = 5'(a1);
        rs2_addr  = 5'(a2);
        #2 rst_n  = 1'b0;
        #1;
        modelReset();
        pushExpected("mid_reset");
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        rs1_addr  = '0;
        rs2_addr  = 5'd5;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        pushExpected("in_reset");
        checkOutput();
        rst_n = 1'b1;

        applyStimulus("rst_a0", 1'b0, 5, 1'b0, 0, 32'h0, 0, 5);
        cmp("rst_a0.rs2_data_const", rs2_data, 32'h0);
        cmp("rst_a0.ready_const", 32'(iss_ready), 32'd1);
        applyStimulus("rst_a31", 1'b0, 0, 1'b0, 0, 32'h0, 31, 5);
        cmp("rst_a31.rs1_data_const", rs1_data, 32'h0);

        applyStimulus("iss5", 1'b1, 5, 1'b0, 0, 32'h0, 5, 0);
        applyStimulus("wb5", 1'b0, 0, 1'b1, 5, 32'hDEADBEEF, 5, 0);
`ifndef REGFILE_BYPASS_EN
        cmp("wb5.busy_const", 32'(rs1_busy), 32'd1);
`endif
        applyStimulus("rd5", 1'b0, 0, 1'b0, 0, 32'h0, 5, 0);
        cmp("rd5.data_const", rs1_data, 32'hDEADBEEF);
        cmp("rd5.busy_const", 32'(rs1_busy), 32'd0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus("iss7", 1'b1, 7, 1'b0, 0, 32'h0, 7, 0);
        end
        applyStimulus("iss7_full", 1'b1, 7, 1'b0, 0, 32'h0, 7, 0);
        cmp("iss7_full.ready_const", 32'(iss_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("wb7", 1'b0, 7, 1'b1, 7, 32'h700 + 32'(i), 7, 0);
        end
        applyStimulus("rd7", 1'b0, 7, 1'b0, 0, 32'h0, 7, 0);
        cmp("rd7.busy_const", 32'(rs1_busy), 32'd0);
        cmp("rd7.data_const", rs1_data, 32'h702);
        cmp("rd7.ready_const", 32'(iss_ready), 32'd1);

        applyStimulus("wb0_iss0", 1'b1, 0, 1'b1, 0, 32'h12345678, 0, 0);
        cmp("wb0_iss0.ready_const", 32'(iss_ready), 32'd1);
        applyStimulus("rd0", 1'b0, 0, 1'b0, 0, 32'h0, 0, 0);
        cmp("rd0.data_const", rs1_data, 32'h0);
        cmp("rd0.err_const", 32'(sb_err), 32'd0);

        applyStimulus("wb9", 1'b0, 0, 1'b1, 9, 32'hCAFE0009, 9, 0);
        applyStimulus("rd9", 1'b0, 0, 1'b0, 0, 32'h0, 9, 0);
        cmp("rd9.data_const", rs1_data, 32'hCAFE0009);
        cmp("rd9.err_const", 32'(sb_err), 32'd1);

        applyStimulus("iss3", 1'b1, 3, 1'b0, 0, 32'h0, 3, 3);
        applyStimulus("iss3_wb3", 1'b1, 3, 1'b1, 3, 32'hA5A5A5A5, 3, 3);
`ifdef REGFILE_BYPASS_EN
        cmp("iss3_wb3.fwd_data_const", rs2_data, 32'hA5A5A5A5);
        cmp("iss3_wb3.fwd_busy_const", 32'(rs2_busy), 32'd0);
`endif
        applyStimulus("rd3", 1'b0, 0, 1'b0, 0, 32'h0, 3, 3);
        cmp("rd3.busy_const", 32'(rs2_busy), 32'd1);
        cmp("rd3.data_const", rs2_data, 32'hA5A5A5A5);
        cmp("rd3.err_const", 32'(sb_err), 32'd1);

        midReset(3, 9);
        applyStimulus("post_rst", 1'b0, 3, 1'b0, 0, 32'h0, 3, 9);
        cmp("post_rst.busy_const", 32'(rs1_busy), 32'd0);
        cmp("post_rst.data_const", rs2_data, 32'h0);
        cmp("post_rst.err_const", 32'(sb_err), 32'd0);
        applyStimulus("post_rst_a5", 1'b0, 0, 1'b0, 0, 32'h0, 5, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file with an integrated write scoreboard for the pipelined datapath. It provides two asynchronous read ports and one synchronous write-back port. Per-register pending-write counters tell decode whether an operand is still awaiting write-back. Register 0 is hardwired to zero and never pending. The block replaces the single-cycle register file in the multi-cycle/pipelined core, sitting between decode (reads, issue) and write-back.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- PEND_W, 2, width of each pending-write counter; max in-flight writes per register = 2^PEND_W − 1
- AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_data, rs2_data  out  XLEN  read data (combinational)
- rs1_busy, rs2_busy  out  1  operand has pending write (combinational)
- iss_valid  in  1  decode issues an instruction writing iss_rd
- iss_rd  in  AW  destination of issued instruction
- iss_ready  out  1  issue may be accepted this cycle (combinational)
- wb_valid  in  1  write-back strobe
- wb_addr  in  AW  write-back address
- wb_data  in  XLEN  write-back data
- sb_err  out  1  sticky error: write-back to a register with zero pending count

## Operation
- Storage: regs[1..NREGS-1] of XLEN; cnt[1..NREGS-1] of PEND_W bits. Address 0 is not stored.
- Read: rsN_data = 0 if rsN_addr==0, else regs[rsN_addr]. rsN_busy = 0 if addr==0, else (cnt[addr] != 0).
- iss_ready = 1 if iss_rd==0, else (cnt[iss_rd] != 2^PEND_W−1). Issue is accepted on iss_valid && iss_ready.
- Write: on wb_valid && wb_addr!=0, regs[wb_addr] <= wb_data. Writes to address 0 are discarded.
- Counter update per register r≠0, per edge:
  - inc = accepted issue to r; dec = wb_valid to r with cnt[r]!=0.
  - inc && dec: unchanged.
  - inc only: +1.
  - dec only: −1.
- Write-back to r≠0 with cnt[r]==0: data is still written, cnt stays 0, sb_err set.
- sb_err is cleared only by reset.
- iss_valid while !iss_ready: ignored, no state change.
- Reset (asserted at any time, including mid-operation): all regs = 0, all cnt = 0, sb_err = 0. Outputs after reset: rsN_data = 0, rsN_busy = 0, iss_ready = 1, sb_err = 0.

## Timing
- Read latency 0 (combinational from address and state).
- Write-back visible on reads the cycle after the wb edge, unless bypass is enabled.
- Counter changes are visible on busy/iss_ready the cycle after the edge.
- Full counter plus a same-cycle wb to the same register: iss_ready still 0 (conservative); the issue retries next cycle.
- Reset is asynchronous on assertion; deassertion is assumed synchronised externally.

## Configuration
- REGFILE_BYPASS_EN defined: when wb_valid && wb_addr==rsN_addr && addr!=0:
  - rsN_data = wb_data.
  - rsN_busy = (cnt[addr] > 1).
  - The write-back is forwarded in the same cycle.
- REGFILE_BYPASS_EN undefined: reads and busy reflect registered state only, with no wb→read combinational path.

## Structure
- Shared package regfile_pkg:
  - default XLEN/NREGS/PEND_W localparams.
  - typedef for register address.
  - typedef for pending-count.
- One sub-module, regfile_pend_ctr: a single saturating up/down counter with inc, dec, full, nonzero and underflow outputs. It is generated NREGS−1 times.

## Test plan
- Reset, then read addresses 0, 5 and 31 → all data 0, busy 0, iss_ready 1, sb_err 0.
- Issue rd=5; next cycle wb 5 ← 0xDEADBEEF:
  - rs1_busy=1 for addr 5 between issue and wb.
  - After the wb edge: rs1_data=0xDEADBEEF, busy=0.
- Issue rd=7 three times (PEND_W=2):
  - iss_ready drops to 0 after the third issue.
  - A fourth iss_valid is ignored.
  - Three wbs return cnt to 0.
  - busy clears after the third wb.
- Wb to 0 ← 0x12345678 and issue rd=0 → reads of 0 return 0, busy 0, iss_ready 1 throughout.
- Wb to 9 with no pending issue:
  - regs[9] is updated.
  - sb_err=1 and stays 1 until rst_n pulses low mid-stream.
  - After reset, all state is zero.
- Simultaneous issue and wb to 3 with cnt[3]=1 → cnt stays 1, busy remains 1.
  - With REGFILE_BYPASS_EN and cnt[3]=1, wb 3 ← 0xA5A5A5A5 → same-cycle rs2_data=0xA5A5A5A5, rs2_busy=0.
